// File: rtl/hart_sched_pkg.sv
// Shared constants and the per-hart state encoding for the FMRT Mini Core
// fine-grained multithreading scheduler.
package hart_sched_pkg;

  localparam int HART_NUM_DEF = 4;
  localparam int HART_STATE_B = HART_NUM_DEF;
  localparam logic [HART_STATE_B-1:0] BOOT_MASK_DEF = 4'b0001;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'b00,
    HS_READY   = 2'b01,
    HS_WAIT_BR = 2'b10,
    HS_WAIT_LD = 2'b11
  } hs_e;

endpackage

// File: rtl/hart_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// after the last-granted index, wrapping from N-1 back to 0.
module hart_rr_arb #(
  parameter int  N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_sched.sv
// Fetch scheduler: per-hart park/resolve state machines plus round-robin
// selection of the hart that IF fetches for next.
module hart_sched
  import hart_sched_pkg::*;
#(
  parameter int                 HART_NUM  = HART_NUM_DEF,
  parameter logic [HART_NUM-1:0] BOOT_MASK = HART_NUM'(BOOT_MASK_DEF),
  localparam int                PW        = (HART_NUM > 1) ? $clog2(HART_NUM) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [HART_NUM-1:0] id_hstate,
  input  logic                is_branch,
  input  logic                is_load,
  input  logic                br_done,
  input  logic [HART_NUM-1:0] br_hstate,
  input  logic                ld_done,
  input  logic [HART_NUM-1:0] ld_hstate,
  input  logic [HART_NUM-1:0] hart_start,
  input  logic [HART_NUM-1:0] hart_kill,
  output logic [HART_NUM-1:0] if_hart_st,
  output logic                if_flush,
  output logic [HART_NUM-1:0] hart_active,
  output logic                all_idle
);

  logic [HART_NUM-1:0] ready_d;
  logic [HART_NUM-1:0] active_d;
  logic [HART_NUM-1:0] park_vec;
  logic [HART_NUM-1:0] grant;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       grant_idx;
  logic                flush_d;

  for (genvar i = 0; i < HART_NUM; i++) begin : g_hart
    hs_e  state_q;
    hs_e  state_d;
    logic park_fire;

    // Later assignments override earlier ones: resolve < park < start < kill.
    // Parking is checked against the post-resolve state so that a park in the
    // same cycle as a resolution wins (the resolution belongs to the older op).
    always_comb begin
      state_d   = state_q;
      park_fire = 1'b0;
      if (state_q == HS_WAIT_BR && br_done && br_hstate[i]) state_d = HS_READY;
      if (state_q == HS_WAIT_LD && ld_done && ld_hstate[i]) state_d = HS_READY;
      if (!stall && id_hstate[i] && (is_branch || is_load) && state_d == HS_READY) begin
        park_fire = 1'b1;
        state_d   = is_branch ? HS_WAIT_BR : HS_WAIT_LD;
      end
      if (hart_start[i] && state_q == HS_IDLE) state_d = HS_READY;
      if (hart_kill[i]) begin
        park_fire = 1'b0;
        state_d   = HS_IDLE;
      end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= BOOT_MASK[i] ? HS_READY : HS_IDLE;
      else        state_q <= state_d;
    end

    assign ready_d[i]  = (state_d == HS_READY);
    assign active_d[i] = (state_d != HS_IDLE);
    assign park_vec[i] = park_fire;
  end

  // Grant from next-state READY: parked harts drop out, released harts join now.
  hart_rr_arb #(.N(HART_NUM)) u_arb (
    .req   (ready_d),
    .last  (ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = ptr_q;
    for (int i = 0; i < HART_NUM; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // The fetched instruction is younger than the one parking its own hart.
  assign flush_d = !stall && (|(park_vec & id_hstate)) && (id_hstate == if_hart_st);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_hart_st  <= '0;
      ptr_q       <= PW'(HART_NUM - 1);
      if_flush    <= 1'b0;
      hart_active <= BOOT_MASK;
      all_idle    <= (BOOT_MASK == '0);
    end else begin
      if_flush    <= flush_d;
      hart_active <= active_d;
      all_idle    <= ~|active_d;
      if (!stall) begin
        if_hart_st <= grant;
        if (|grant) ptr_q <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hart_sched.sv
// Directed, table-driven bench for hart_sched: one vector per clock with
// hand-computed expected outputs, plus reset sequences.
module tb_hart_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [3:0] id_hstate;
  logic       is_branch;
  logic       is_load;
  logic       br_done;
  logic [3:0] br_hstate;
  logic       ld_done;
  logic [3:0] ld_hstate;
  logic [3:0] hart_start;
  logic [3:0] hart_kill;
  logic [3:0] if_hart_st;
  logic       if_flush;
  logic [3:0] hart_active;
  logic       all_idle;

  int passed = 0;
  int total  = 0;

  hart_sched dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .id_hstate   (id_hstate),
    .is_branch   (is_branch),
    .is_load     (is_load),
    .br_done     (br_done),
    .br_hstate   (br_hstate),
    .ld_done     (ld_done),
    .ld_hstate   (ld_hstate),
    .hart_start  (hart_start),
    .hart_kill   (hart_kill),
    .if_hart_st  (if_hart_st),
    .if_flush    (if_flush),
    .hart_active (hart_active),
    .all_idle    (all_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic [3:0] id;
    logic       br;
    logic       ld;
    logic       brd;
    logic [3:0] brh;
    logic       ldd;
    logic [3:0] ldh;
    logic [3:0] start;
    logic [3:0] kill;
    logic [3:0] e_if;
    logic       e_fl;
    logic [3:0] e_act;
    logic       e_idle;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  function automatic vec_t v(input logic s, input logic [3:0] id, input logic b, input logic l,
                             input logic bd, input logic [3:0] bh, input logic lnd, input logic [3:0] lh,
                             input logic [3:0] st, input logic [3:0] kl,
                             input logic [3:0] eif, input logic efl, input logic [3:0] eact,
                             input logic eidle);
    vec_t r;
    r = '{stall: s, id: id, br: b, ld: l, brd: bd, brh: bh, ldd: lnd, ldh: lh,
          start: st, kill: kl, e_if: eif, e_fl: efl, e_act: eact, e_idle: eidle};
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
    else passed++;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eif, input logic efl,
                           input logic [3:0] eact, input logic eidle);
    check({tag, " if_hart_st"},  if_hart_st,        eif);
    check({tag, " if_flush"},    {3'b0, if_flush},  {3'b0, efl});
    check({tag, " hart_active"}, hart_active,       eact);
    check({tag, " all_idle"},    {3'b0, all_idle},  {3'b0, eidle});
  endtask

  initial begin
    //             stall id      br  ld  brd brh     ldd ldh     start   kill     if      fl  act     idle
    // boot hart 0 only: self grants
    vecs[0]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
    vecs[1]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
    // start harts 1-3, rotation with wrap
    vecs[2]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1110, 4'b0000, 4'b0010, 0, 4'b1111, 0);
    vecs[3]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b1111, 0);
    vecs[4]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1111, 0);
    vecs[5]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b1111, 0);
    vecs[6]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 4'b1111, 0);
    // hart 1 parks on a branch while it is being fetched -> flush, skipped
    vecs[7]  = v(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1, 4'b1111, 0);
    vecs[8]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1111, 0);
    vecs[9]  = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b1111, 0);
    vecs[10] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b1111, 0);
    vecs[11] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1111, 0);
    vecs[12] = v(0, 4'b0000, 0, 0, 1, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b1111, 0);
    vecs[13] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 4'b1111, 0);
    // hart 2 load park, resolve+park same cycle, wrong-type resolve, release
    vecs[14] = v(0, 4'b0100, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1111, 0);
    vecs[15] = v(0, 4'b0100, 0, 1, 0, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 0, 4'b1111, 0);
    vecs[16] = v(0, 4'b0000, 0, 0, 1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 4'b1111, 0);
    vecs[17] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 4'b1111, 0);
    // only hart 0 left; it parks on a load -> fetch bubbles until released
    vecs[18] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 0, 4'b0001, 0);
    vecs[19] = v(0, 4'b0001, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 0);
    vecs[20] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    vecs[21] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    vecs[22] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
    // branch+load together is a branch: ld_done ignored, br_done releases
    vecs[23] = v(0, 4'b0001, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 0);
    vecs[24] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    vecs[25] = v(0, 4'b0000, 0, 0, 1, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
    // stall with a branch in ID: frozen, then park+flush when stall drops
    vecs[26] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 0, 4'b0111, 0);
    vecs[27] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0111, 0);
    vecs[28] = v(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0111, 0);
    vecs[29] = v(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0111, 0);
    vecs[30] = v(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0111, 0);
    vecs[31] = v(0, 4'b0100, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 4'b0111, 0);
    // kill all during stall, then start during stall
    vecs[32] = v(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 0, 4'b0000, 1);
    vecs[33] = v(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0000, 1);
    vecs[34] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1);
    vecs[35] = v(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 0);
    vecs[36] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1000, 0);
    vecs[37] = v(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1000, 0);

    reset      = 1'b0;
    stall      = 1'b0;
    id_hstate  = '0;
    is_branch  = 1'b0;
    is_load    = 1'b0;
    br_done    = 1'b0;
    br_hstate  = '0;
    ld_done    = 1'b0;
    ld_hstate  = '0;
    hart_start = '0;
    hart_kill  = '0;

    repeat (2) @(negedge clk);
    check_all("reset", 4'b0000, 1'b0, 4'b0001, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall      = vecs[i].stall;
      id_hstate  = vecs[i].id;
      is_branch  = vecs[i].br;
      is_load    = vecs[i].ld;
      br_done    = vecs[i].brd;
      br_hstate  = vecs[i].brh;
      ld_done    = vecs[i].ldd;
      ld_hstate  = vecs[i].ldh;
      hart_start = vecs[i].start;
      hart_kill  = vecs[i].kill;
      @(negedge clk);
      check_all($sformatf("v%0d", i), vecs[i].e_if, vecs[i].e_fl, vecs[i].e_act, vecs[i].e_idle);
    end

    // Asynchronous reset mid-operation: hart 3 is being fetched with a
    // load resolution in flight; reset must take effect before the next edge.
    ld_done   = 1'b1;
    ld_hstate = 4'b1000;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all("async_reset", 4'b0000, 1'b0, 4'b0001, 1'b0);
    @(negedge clk);
    ld_done   = 1'b0;
    ld_hstate = '0;
    reset     = 1'b1;
    @(negedge clk);
    check_all("post_reset", 4'b0001, 1'b0, 4'b0001, 1'b0);
    @(negedge clk);
    check_all("post_reset2", 4'b0001, 1'b0, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hart_sched.md
# hart_sched

Fine-grained multithreading scheduler for the FMRT Mini Core front end. Each cycle it picks which hart the IF stage fetches for. It tracks a per-hart state machine that parks a hart when ID decodes a branch or load for it, and releases the hart when EX or MEM reports resolution. It sits between the ID/EX/MEM stages and IF, and drives the hart-state tag that travels down the pipeline with each instruction.

## Interface
- HART_NUM, 4, number of harts; hart-state bus is one-hot, HART_NUM bits wide
- BOOT_MASK, 4'b0001, harts placed in READY at reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; holds the fetch selection
- id_hstate  in  HART_NUM  one-hot hart owning the instruction in ID (zero = bubble)
- is_branch  in  1  ID instruction is a branch/JAL/JALR
- is_load  in  1  ID instruction is a load
- br_done  in  1  EX resolved the branch of hart br_hstate
- br_hstate  in  HART_NUM  one-hot owner of the resolved branch
- ld_done  in  1  MEM returned load data for hart ld_hstate
- ld_hstate  in  HART_NUM  one-hot owner of the returned load
- hart_start  in  HART_NUM  per-hart activate request (IDLE->READY)
- hart_kill  in  HART_NUM  per-hart deactivate request (any->IDLE)
- if_hart_st  out  HART_NUM  one-hot hart selected for fetch; zero = fetch bubble
- if_flush  out  1  squash the IF instruction (same hart just parked)
- hart_active  out  HART_NUM  hart state != IDLE
- all_idle  out  1  every hart IDLE

## Operation
- Per-hart FSM, 2-bit encoding:
  - IDLE→READY on hart_start.
  - READY→WAIT_BR when ID shows that hart with is_branch.
  - READY→WAIT_LD when ID shows that hart with is_load.
  - WAIT_BR→READY on br_done for that hart.
  - WAIT_LD→READY on ld_done for that hart.
  - any→IDLE on hart_kill.
- If is_branch and is_load are both set, treat the instruction as a branch.
- Priority per hart per cycle: kill > start > ID park > resolve.
  - Resolve and park for the same hart in the same cycle: final state is the park state. The resolution belongs to the older instruction.
  - hart_start on a non-IDLE hart is ignored.
  - br_done for a hart in WAIT_LD (or the reverse) is ignored.
- Selection: round-robin over harts in READY.
  - Search starts at the bit after the last granted hart and wraps from HART_NUM-1 to 0.
  - The pointer advances only when a grant is issued.
  - No READY hart: if_hart_st = 0 and the pointer holds.
- The selection is computed from next-state READY. A hart parked this cycle is not granted this cycle; a hart released this cycle may be granted this cycle.
- if_flush = 1 (registered) when a park occurs and id_hstate equals the current if_hart_st. That fetched instruction is younger than the parking instruction and must be squashed.
- During stall:
  - if_hart_st and the pointer hold.
  - ID park transitions are suppressed. ID holds its instruction, so the park is taken on the first non-stall cycle.
  - start, kill and resolve still apply.
  - if_flush = 0.

## Timing
- Reset values:
  - Harts in BOOT_MASK READY, others IDLE.
  - if_hart_st = 0, pointer = HART_NUM-1 (so hart 0 wins first).
  - if_flush = 0.
  - hart_active = BOOT_MASK; all_idle = (BOOT_MASK == 0).
- All outputs are registered.
- Latency:
  - Park in ID at cycle t: state visible at t+1, and the hart is excluded from the grant issued at t+1.
  - Resolution at t: the hart is eligible in the grant issued at t+1.
  - hart_start at t: the hart can appear on if_hart_st at t+1.
- if_flush is a one-cycle pulse, aligned with the if_hart_st update.
- A single ready hart is granted every cycle: back-to-back self grants are allowed.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). In-flight resolutions are discarded.

## Structure
- Add to hart_ctrl.h: the HART_NUM default, HART_STATE_B bus width, the 2-bit FSM state encodings (HS_IDLE, HS_READY, HS_WAIT_BR, HS_WAIT_LD), and the BOOT_MASK default.
- One sub-module, hart_rr_arb:
  - Inputs: request mask, last-grant pointer.
  - Output: one-hot grant.
  - Pure combinational, so it can be reused by the MEM-port arbiter.
- The per-hart FSMs live in a generate loop in hart_sched.

## Test plan
- Reset with BOOT_MASK=0001, no stimulus → if_hart_st = 0001 every cycle from the first cycle after reset release; all_idle = 0.
- hart_start = 1110 at t → from t+1 grants rotate 0010, 0100, 1000, 0001, 0010…; pointer wraps 3→0.
- Hart 1 decodes a branch (id_hstate = 0010, is_branch) while if_hart_st = 0010 → at t+1 hart 1 is WAIT_BR, if_flush = 1, hart 1 not granted. br_done with br_hstate = 0010 at t+5 → hart 1 granted again by t+6 in rotation.
- Same cycle: ld_done for hart 2 in WAIT_LD plus ID park of hart 2 with is_load → hart 2 stays WAIT_LD; a second ld_done releases it.
- Only hart 0 READY, hart 0 parks on a load → if_hart_st = 0 until ld_done; pointer unchanged; on release the grant returns to 0001.
- stall held 3 cycles with a branch in ID → if_hart_st frozen and no park during stall; park and if_flush occur on the cycle stall drops. hart_kill = 1111 during the stall → all_idle = 1 next cycle and if_hart_st = 0 after stall.
